// File: rtl/pwm_duty_ramp_controller.sv
// pwm_duty_ramp_controller
//
// Turns a requested target duty into the PWM byte that the FET driver latches
// at each period boundary. The duty moves only on a period tick, which is the
// rising edge of the driver's CYCLE output. It ramps toward the target by STEP
// on each tick. It backs off by BACKOFF when a voltage or current limit is
// seen, then holds for HOLD_CYCLES periods. A driver fault or a dropped
// ENABLE forces the duty to zero on the very next clock.
//
// Ports:
//   CLK          : single clock, shared with the driver
//   RESET        : synchronous, active-high reset
//   ENABLE       : run request; low forces IDLE with zero duty
//   TARGET[7:0]  : requested duty, clamped to MAX_PWM
//   STEP[3:0]    : ramp increment per period; a value of 0 acts as 1
//   BACKOFF[3:0] : duty decrement applied on each limit backoff
//   HOLD_CYCLES  : periods to hold after a backoff before ramping resumes
//   CYCLE        : driver end-of-period level; only its rising edge is used
//   FAULT_DETECT : sticky driver fault
//   V_LIMIT      : asynchronous voltage-limit comparator
//   I_LIMIT      : asynchronous current-limit comparator
//   PWM[7:0]     : registered duty sent to the driver
//   STATE[2:0]   : current FSM state code (IDLE=0, RAMP=1, STEADY=2,
//                  BACKOFF=3, FAULT=4)
//   AT_TARGET    : high in STEADY while PWM equals the effective target
//   LIMIT_COUNT  : number of limit backoffs, saturating at 8'hFF

module pwm_duty_ramp_controller #(
    parameter logic [7:0] MAX_PWM = 8'hF0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [7:0] TARGET,
    input  logic [3:0] STEP,
    input  logic [3:0] BACKOFF,
    input  logic [3:0] HOLD_CYCLES,
    input  logic       CYCLE,
    input  logic       FAULT_DETECT,
    input  logic       V_LIMIT,
    input  logic       I_LIMIT,
    output logic [7:0] PWM,
    output logic [2:0] STATE,
    output logic       AT_TARGET,
    output logic [7:0] LIMIT_COUNT
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RAMP    = 3'd1;
    localparam logic [2:0] ST_STEADY  = 3'd2;
    localparam logic [2:0] ST_BACKOFF = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;

    logic       lim_sync1;
    logic       lim_sync2;
    logic       limit_seen;
    logic       cycle_q;
    logic [3:0] hold_cnt;

    logic       tick;
    logic [7:0] target_eff;
    logic [3:0] step_eff;
    logic [8:0] up_sum;
    logic [8:0] dn_diff;
    logic [8:0] bo_diff;
    logic [7:0] ramp_next;
    logic [7:0] bo_next;
    logic [7:0] cnt_next;

    assign tick       = CYCLE & ~cycle_q;
    assign target_eff = (TARGET > MAX_PWM) ? MAX_PWM : TARGET;
    assign step_eff   = (STEP == 4'd0) ? 4'd1 : STEP;

    // Nine-bit arithmetic keeps the carry or borrow, so the clamps below
    // can never wrap past the target or past zero.
    assign up_sum  = {1'b0, PWM} + {5'b0, step_eff};
    assign dn_diff = {1'b0, PWM} - {5'b0, step_eff};
    assign bo_diff = {1'b0, PWM} - {5'b0, BACKOFF};

    always_comb begin
        ramp_next = PWM;
        if (PWM < target_eff) begin
            ramp_next = (up_sum >= {1'b0, target_eff}) ? target_eff : up_sum[7:0];
        end else if (PWM > target_eff) begin
            ramp_next = (dn_diff[8] || (dn_diff[7:0] <= target_eff)) ? target_eff : dn_diff[7:0];
        end
    end

    assign bo_next   = bo_diff[8] ? 8'd0 : bo_diff[7:0];
    assign cnt_next  = (LIMIT_COUNT == 8'hFF) ? 8'hFF : LIMIT_COUNT + 8'd1;
    assign AT_TARGET = (STATE == ST_STEADY) && (PWM == target_eff);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lim_sync1   <= 1'b0;
            lim_sync2   <= 1'b0;
            limit_seen  <= 1'b0;
            cycle_q     <= 1'b0;
            hold_cnt    <= 4'd0;
            PWM         <= 8'd0;
            STATE       <= ST_IDLE;
            LIMIT_COUNT <= 8'd0;
        end else begin
            lim_sync1 <= V_LIMIT | I_LIMIT;
            lim_sync2 <= lim_sync1;
            cycle_q   <= CYCLE;
            // Cleared on a tick, but a limit arriving on that same clock
            // sets it again, so the event carries into the next period.
            limit_seen <= lim_sync2 | (limit_seen & ~tick);

            if (FAULT_DETECT) begin
                STATE <= ST_FAULT;
                PWM   <= 8'd0;
            end else if (!ENABLE) begin
                STATE <= ST_IDLE;
                PWM   <= 8'd0;
            end else begin
                case (STATE)
                    ST_IDLE: begin
                        PWM   <= 8'd0;
                        STATE <= ST_RAMP;
                    end
                    ST_RAMP: begin
                        if (tick) begin
                            if (limit_seen) begin
                                STATE       <= ST_BACKOFF;
                                PWM         <= bo_next;
                                LIMIT_COUNT <= cnt_next;
                                hold_cnt    <= HOLD_CYCLES;
                            end else begin
                                PWM <= ramp_next;
                                if (ramp_next == target_eff) begin
                                    STATE <= ST_STEADY;
                                end
                            end
                        end
                    end
                    ST_STEADY: begin
                        if (tick) begin
                            if (limit_seen) begin
                                STATE       <= ST_BACKOFF;
                                PWM         <= bo_next;
                                LIMIT_COUNT <= cnt_next;
                                hold_cnt    <= HOLD_CYCLES;
                            end else if (PWM != target_eff) begin
                                STATE <= ST_RAMP;
                            end
                        end
                    end
                    ST_BACKOFF: begin
                        if (tick) begin
                            if (limit_seen) begin
                                PWM         <= bo_next;
                                LIMIT_COUNT <= cnt_next;
                                hold_cnt    <= HOLD_CYCLES;
                            end else if (hold_cnt == 4'd0) begin
                                STATE <= ST_RAMP;
                            end else begin
                                hold_cnt <= hold_cnt - 4'd1;
                            end
                        end
                    end
                    ST_FAULT: begin
                        // Held here until ENABLE drops, even after the fault clears.
                        PWM <= 8'd0;
                    end
                    default: begin
                        STATE <= ST_IDLE;
                        PWM   <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp_controller.sv
// Testbench for pwm_duty_ramp_controller.
// The stimulus tasks push the expected {STATE, PWM, LIMIT_COUNT, AT_TARGET}
// into exp_q. The monitor pops one entry on the falling edge after each
// period tick, or after each explicit probe, and compares it.

module tb_pwm_duty_ramp_controller;

    localparam int W = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] target = 8'h40;
    logic [3:0] step = 4'd4;
    logic [3:0] backoff = 4'd8;
    logic [3:0] hold_cycles = 4'd2;
    logic       cycle = 1'b0;
    logic       fault_detect = 1'b0;
    logic       v_limit = 1'b0;
    logic       i_limit = 1'b0;
    logic [7:0] pwm;
    logic [2:0] state;
    logic       at_target;
    logic [7:0] limit_count;

    pwm_duty_ramp_controller dut (
        .CLK          (clk),
        .RESET        (reset),
        .ENABLE       (enable),
        .TARGET       (target),
        .STEP         (step),
        .BACKOFF      (backoff),
        .HOLD_CYCLES  (hold_cycles),
        .CYCLE        (cycle),
        .FAULT_DETECT (fault_detect),
        .V_LIMIT      (v_limit),
        .I_LIMIT      (i_limit),
        .PWM          (pwm),
        .STATE        (state),
        .AT_TARGET    (at_target),
        .LIMIT_COUNT  (limit_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           total = 0;
    int           bad = 0;

    logic cyc_q = 1'b0;
    logic tick_d = 1'b0;
    logic probe_req = 1'b0;
    logic probe_d = 1'b0;
    logic fin_req = 1'b0;
    logic fin_done = 1'b0;

    // The bench detects the tick on its own, independently of the DUT.
    always @(posedge clk) begin
        cyc_q   <= cycle;
        tick_d  <= cycle & ~cyc_q;
        probe_d <= probe_req;
    end

    function automatic logic [W-1:0] mk(input logic [2:0] s, input logic [7:0] p,
                                        input logic [7:0] c, input logic a);
        return {s, p, c, a};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] e;
        string        nm;
        got = {state, pwm, limit_count, at_target};
        if (tick_d || probe_d) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_sample: got st=%0d pwm=%h cnt=%h at=%b, required no sample",
                         got[19:17], got[16:9], got[8:1], got[0]);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: got st=%0d pwm=%h cnt=%h at=%b, required st=%0d pwm=%h cnt=%h at=%b",
                             nm, got[19:17], got[16:9], got[8:1], got[0],
                             e[19:17], e[16:9], e[8:1], e[0]);
                end
            end
        end
        if (fin_req && !fin_done) begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL leftover_expectations: got %0d pending, required 0", exp_q.size());
            end
            fin_done = 1'b1;
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic push(input logic [W-1:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic do_tick(input logic [W-1:0] e, input string nm, input int gap);
        cycle = 1'b1;
        push(e, nm);
        @(negedge clk);
        cycle = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic probe_next(input logic [W-1:0] e, input string nm);
        push(e, nm);
        probe_req = 1'b1;
        @(negedge clk);
        probe_req = 1'b0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        wait_clks(2);
        probe_next(mk(3'd0, 8'h00, 8'h00, 1'b0), "reset_values");
        reset = 1'b0;
        wait_clks(2);

        // Ramp up by 4 to 0x40, one tick every 20 clocks.
        enable = 1'b1;
        probe_next(mk(3'd1, 8'h00, 8'h00, 1'b0), "idle_to_ramp");
        wait_clks(3);
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) do_tick(mk(3'd2, 8'h40, 8'h00, 1'b1), "ramp_up_final", 20);
            else         do_tick(mk(3'd1, 8'(4 * i), 8'h00, 1'b0), "ramp_up_step", 20);
        end
        do_tick(mk(3'd2, 8'h40, 8'h00, 1'b1), "steady_hold", 20);

        // Limit backoff from STEADY at 0x40: one-clock current-limit pulse.
        i_limit = 1'b1;
        wait_clks(1);
        i_limit = 1'b0;
        wait_clks(6);
        do_tick(mk(3'd3, 8'h38, 8'h01, 1'b0), "backoff_entry", 8);
        do_tick(mk(3'd3, 8'h38, 8'h01, 1'b0), "hold_2_to_1", 8);
        do_tick(mk(3'd3, 8'h38, 8'h01, 1'b0), "hold_1_to_0", 8);
        do_tick(mk(3'd1, 8'h38, 8'h01, 1'b0), "hold_done_ramp", 8);
        do_tick(mk(3'd1, 8'h3C, 8'h01, 1'b0), "recover_step", 8);
        do_tick(mk(3'd2, 8'h40, 8'h01, 1'b1), "recover_steady", 8);

        // Target above the ceiling with an odd step: stops exactly at 0xF0.
        target = 8'hFF;
        step   = 4'd7;
        do_tick(mk(3'd1, 8'h40, 8'h01, 1'b0), "clamp_leave_steady", 6);
        for (int k = 1; k <= 25; k++)
            do_tick(mk(3'd1, 8'(64 + 7 * k), 8'h01, 1'b0), "clamp_up_step", 6);
        do_tick(mk(3'd2, 8'hF0, 8'h01, 1'b1), "clamp_at_max", 6);

        // Ramp back down to 0x10 with the same step.
        target = 8'h10;
        do_tick(mk(3'd1, 8'hF0, 8'h01, 1'b0), "down_leave_steady", 6);
        for (int k = 1; k <= 31; k++)
            do_tick(mk(3'd1, 8'(240 - 7 * k), 8'h01, 1'b0), "down_step", 6);
        do_tick(mk(3'd2, 8'h10, 8'h01, 1'b1), "down_exact", 6);

        // Move down to 0x04 to set up the saturation case.
        target = 8'h04;
        step   = 4'd4;
        do_tick(mk(3'd1, 8'h10, 8'h01, 1'b0), "to4_leave", 5);
        do_tick(mk(3'd1, 8'h0C, 8'h01, 1'b0), "to4_a", 5);
        do_tick(mk(3'd1, 8'h08, 8'h01, 1'b0), "to4_b", 5);
        do_tick(mk(3'd2, 8'h04, 8'h01, 1'b1), "to4_steady", 5);

        // Voltage limit held: PWM floors at 0, the counter saturates at 0xFF.
        v_limit = 1'b1;
        wait_clks(5);
        for (int n = 2; n <= 260; n++)
            do_tick(mk(3'd3, 8'h00, (n > 255) ? 8'hFF : 8'(n), 1'b0), "sat_backoff", 4);
        v_limit = 1'b0;
        wait_clks(5);
        do_tick(mk(3'd3, 8'h00, 8'hFF, 1'b0), "sat_sticky_last", 5);
        do_tick(mk(3'd3, 8'h00, 8'hFF, 1'b0), "sat_hold_a", 5);
        do_tick(mk(3'd3, 8'h00, 8'hFF, 1'b0), "sat_hold_b", 5);
        do_tick(mk(3'd1, 8'h00, 8'hFF, 1'b0), "sat_to_ramp", 5);
        do_tick(mk(3'd2, 8'h04, 8'hFF, 1'b1), "sat_recovered", 5);

        // Fault mid-ramp.
        target = 8'h40;
        do_tick(mk(3'd1, 8'h04, 8'hFF, 1'b0), "fault_pre_a", 6);
        do_tick(mk(3'd1, 8'h08, 8'hFF, 1'b0), "fault_pre_b", 6);
        do_tick(mk(3'd1, 8'h0C, 8'hFF, 1'b0), "fault_pre_c", 6);
        fault_detect = 1'b1;
        probe_next(mk(3'd4, 8'h00, 8'hFF, 1'b0), "fault_entry");
        fault_detect = 1'b0;
        wait_clks(3);
        do_tick(mk(3'd4, 8'h00, 8'hFF, 1'b0), "fault_sticky", 6);
        enable = 1'b0;
        probe_next(mk(3'd0, 8'h00, 8'hFF, 1'b0), "fault_exit_idle");
        enable = 1'b1;
        probe_next(mk(3'd1, 8'h00, 8'hFF, 1'b0), "restart_ramp");
        wait_clks(3);
        do_tick(mk(3'd1, 8'h04, 8'hFF, 1'b0), "restart_step", 6);

        // CYCLE held high for 50 clocks gives a single step.
        cycle = 1'b1;
        push(mk(3'd1, 8'h08, 8'hFF, 1'b0), "long_cycle_single_step");
        wait_clks(50);
        cycle = 1'b0;
        wait_clks(3);
        do_tick(mk(3'd1, 8'h0C, 8'hFF, 1'b0), "after_long_cycle", 6);

        // Reset in the middle of a hold.
        i_limit = 1'b1;
        wait_clks(1);
        i_limit = 1'b0;
        wait_clks(6);
        do_tick(mk(3'd3, 8'h04, 8'hFF, 1'b0), "backoff_before_reset", 6);
        do_tick(mk(3'd3, 8'h04, 8'hFF, 1'b0), "holding_before_reset", 3);
        reset = 1'b1;
        probe_next(mk(3'd0, 8'h00, 8'h00, 1'b0), "reset_mid_hold");
        reset = 1'b0;
        probe_next(mk(3'd1, 8'h00, 8'h00, 1'b0), "post_reset_ramp");
        wait_clks(3);
        do_tick(mk(3'd1, 8'h04, 8'h00, 1'b0), "post_reset_step", 6);

        // A STEP of 0 acts as 1; a target of 0 ramps down to 0 and settles.
        step = 4'd0;
        do_tick(mk(3'd1, 8'h05, 8'h00, 1'b0), "step_zero_as_one", 6);
        step   = 4'd4;
        target = 8'h00;
        do_tick(mk(3'd1, 8'h01, 8'h00, 1'b0), "target_zero_step", 6);
        do_tick(mk(3'd2, 8'h00, 8'h00, 1'b1), "target_zero_steady", 6);

        wait_clks(4);
        fin_req = 1'b1;
        for (int t = 0; t < 10 && !fin_done; t++) @(negedge clk);
        if (!fin_done) begin
            $display("FAIL final_check: got no final check, required one");
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
